// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 keyboard receiver.
//   PS2_PFX_EXT / PS2_PFX_BRK : scancode prefixes folded into event flags
//   PS2_FRAME_BITS            : start + 8 data + parity + stop
//   ps2_event_t               : one decoded key event {brk, ext, code}
//   ps2_pfx_state_t           : prefix-folding FSM state
//   ps2_frame_ok()            : start/stop/odd-parity check of a full frame
// -----------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK    = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ps2_event_t;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } ps2_pfx_state_t;

    // Frame layout, LSB first: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
    // Parity is odd over data+parity bits.
    function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
        return ~f[0] & f[10] & (^f[9:1]);
    endfunction

endpackage : ps2_pkg

// File: rtl/ps2_event_fifo.sv
// -----------------------------------------------------------------------------
// ps2_event_fifo
// Synchronous first-word-fall-through FIFO of ps2_event_t.
// Parameters:
//   DEPTH        entries, power of 2, >= 2
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   push_i       write request (event emitted this cycle)
//   push_data_i  event to write
//   ready_i      consumer ready; head is popped when valid_o & ready_i
//   valid_o      FIFO non-empty
//   head_o       head event; holds the last popped event while empty
//   count_o      entries currently stored
//   accept_o     push_i was written this cycle
//   drop_o       push_i was discarded because the FIFO was full with no pop
// -----------------------------------------------------------------------------
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  ps2_event_t               push_data_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output ps2_event_t               head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     accept_o,
    output logic                     drop_o
);

    localparam int AW = $clog2(DEPTH);

    ps2_event_t          mem_q [DEPTH];
    ps2_event_t          last_q;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         count_q,  count_d;
    logic                full;
    logic                pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign valid_o  = (count_q != '0);
    assign pop      = valid_o & ready_i;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign accept_o = push_i & (~full | pop);
    assign drop_o   = push_i & ~accept_o;

    always_comb begin
        count_d = count_q;
        case ({accept_o, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage array is deliberately left out of reset; every entry is
    // written before it can be read, and the visible head comes from last_q
    // while empty, so outputs are still 0 after reset.
    always_ff @(posedge clk) begin
        if (accept_o) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            count_q <= count_d;
            if (accept_o) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= mem_q[rd_ptr_q];
            end
        end
    end

    assign head_o  = valid_o ? mem_q[rd_ptr_q] : last_q;
    assign count_o = count_q;

endmodule : ps2_event_fifo

// File: rtl/ps2_kbd_rx.sv
// -----------------------------------------------------------------------------
// ps2_kbd_rx
// PS/2 keyboard receiver: synchronises the PS/2 pins, deserialises and checks
// 11-bit frames, folds E0/F0 prefixes into make/break events and queues them
// in an event FIFO with a valid/ready consumer interface.
// Optional feature macro: PS2_PRESS_CNT_EN (adds press_cnt, a typematic-
// filtered key press counter).
// Parameters:
//   FIFO_DEPTH   event FIFO entries (power of 2, >= 2)
//   SYNC_STAGES  synchroniser depth for ps2_clk/ps2_data (>= 2)
//   TIMEOUT_CYC  idle clk cycles before a partial frame is aborted
//   CNT_W        press counter width (used only with PS2_PRESS_CNT_EN)
// Ports:
//   clk, rst             system clock, asynchronous active-low reset
//   ps2_clk, ps2_data    raw PS/2 pins
//   ev_valid/ev_ready    FIFO head handshake
//   ev_code/ev_break/ev_ext  head event fields
//   fifo_count           entries stored
//   frame_err, overflow  sticky error flags, cleared by clr_err
//   press_cnt            distinct key presses (PS2_PRESS_CNT_EN only)
// -----------------------------------------------------------------------------
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 50000,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [7:0]                    ev_code,
    output logic                          ev_break,
    output logic                          ev_ext,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          clr_err
`ifdef PS2_PRESS_CNT_EN
    ,
    output logic [CNT_W-1:0]              press_cnt
`endif
);

    localparam int          TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0]  LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        SYNC_STAGES < 2 || TIMEOUT_CYC < 1 || CNT_W < 1) begin : g_bad_param
        $error("ps2_kbd_rx: illegal parameter value");
    end

    // ---------------------------------------------------------------- sync --
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic                   sample;
    logic                   data_bit;

    // NOTE: all state updates in clocked blocks use non-blocking assignments
    // so every flop sees pre-edge values, which is what makes the shift
    // chains below behave as chains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            clk_prev_q  <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    // Falling edge of the synchronised PS/2 clock. prev resets to 0, so an
    // idle-high line after reset produces no spurious pulse.
    assign sample   = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign data_bit = data_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------- deserialiser/timeout --
    logic [3:0]                  bit_cnt_q, bit_cnt_d;
    logic [PS2_FRAME_BITS-2:0]   frame_q,   frame_d;   // stop bit not stored
    logic [TMO_W-1:0]            tmo_q,     tmo_d;
    logic                        byte_vld;
    logic                        frame_bad;
    logic                        timeout;
    logic [7:0]                  rx_byte;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        tmo_d     = '0;
        byte_vld  = 1'b0;
        frame_bad = 1'b0;
        timeout   = 1'b0;

        if (sample) begin
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                if (ps2_frame_ok({data_bit, frame_q})) begin
                    byte_vld = 1'b1;
                end else begin
                    frame_bad = 1'b1;
                end
            end else begin
                frame_d[bit_cnt_q] = data_bit;
                bit_cnt_d          = bit_cnt_q + 1'b1;
            end
        end else if (bit_cnt_q != '0) begin
            // Partial frame waiting for its next edge.
            if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                timeout   = 1'b1;
                bit_cnt_d = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    assign rx_byte = frame_q[8:1];

    // ---------------------------------------------------------- prefix FSM --
    ps2_pfx_state_t pfx_q, pfx_d;
    logic           emit;
    ps2_event_t     emit_ev;

    always_comb begin
        pfx_d        = pfx_q;
        emit         = 1'b0;
        emit_ev.brk  = 1'b0;
        emit_ev.ext  = 1'b0;
        emit_ev.code = rx_byte;

        if (frame_bad || timeout) begin
            pfx_d = IDLE;
        end else if (byte_vld) begin
            case (pfx_q)
                IDLE: begin
                    if (rx_byte == PS2_PFX_EXT) begin
                        pfx_d = EXT;
                    end else if (rx_byte == PS2_PFX_BRK) begin
                        pfx_d = BRK;
                    end else begin
                        emit = 1'b1;
                    end
                end
                EXT: begin
                    if (rx_byte == PS2_PFX_BRK) begin
                        pfx_d = EXT_BRK;
                    end else if (rx_byte != PS2_PFX_EXT) begin
                        emit        = 1'b1;
                        emit_ev.ext = 1'b1;
                        pfx_d       = IDLE;
                    end
                end
                BRK: begin
                    if (rx_byte != PS2_PFX_BRK && rx_byte != PS2_PFX_EXT) begin
                        emit        = 1'b1;
                        emit_ev.brk = 1'b1;
                        pfx_d       = IDLE;
                    end
                end
                EXT_BRK: begin
                    // Repeated prefixes here carry no new information.
                    if (rx_byte != PS2_PFX_BRK && rx_byte != PS2_PFX_EXT) begin
                        emit        = 1'b1;
                        emit_ev.brk = 1'b1;
                        emit_ev.ext = 1'b1;
                        pfx_d       = IDLE;
                    end
                end
                default: pfx_d = IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- FIFO --
    ps2_event_t head;
    logic       fifo_accept;
    logic       fifo_drop;

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (emit),
        .push_data_i (emit_ev),
        .ready_i     (ev_ready),
        .valid_o     (ev_valid),
        .head_o      (head),
        .count_o     (fifo_count),
        .accept_o    (fifo_accept),
        .drop_o      (fifo_drop)
    );

    assign ev_code  = head.code;
    assign ev_break = head.brk;
    assign ev_ext   = head.ext;

    // --------------------------------------------------------- error flags --
    logic frame_err_q, frame_err_d;
    logic overflow_q,  overflow_d;

    // A new error in the same cycle as clr_err keeps the flag set.
    always_comb begin
        frame_err_d = frame_err_q;
        overflow_d  = overflow_q;
        if (clr_err) begin
            frame_err_d = 1'b0;
            overflow_d  = 1'b0;
        end
        if (frame_bad || timeout) frame_err_d = 1'b1;
        if (fifo_drop)            overflow_d  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            tmo_q       <= '0;
            pfx_q       <= IDLE;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            tmo_q       <= tmo_d;
            pfx_q       <= pfx_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

`ifdef PS2_PRESS_CNT_EN
    // ------------------------------------------------------- press counter --
    // Counts makes that actually enter the FIFO. A make equal to the last
    // counted key is a typematic repeat until that key's break is seen.
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             lock_vld_q,  lock_vld_d;
    logic [8:0]       lock_key_q,  lock_key_d;
    logic [8:0]       ev_key;

    assign ev_key = {emit_ev.ext, emit_ev.code};

    always_comb begin
        press_cnt_d = press_cnt_q;
        lock_vld_d  = lock_vld_q;
        lock_key_d  = lock_key_q;
        if (fifo_accept) begin
            if (!emit_ev.brk) begin
                if (!(lock_vld_q && lock_key_q == ev_key)) begin
                    press_cnt_d = press_cnt_q + CNT_W'(1);
                    lock_vld_d  = 1'b1;
                    lock_key_d  = ev_key;
                end
            end else if (lock_vld_q && lock_key_q == ev_key) begin
                lock_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_cnt_q <= '0;
            lock_vld_q  <= 1'b0;
            lock_key_q  <= '0;
        end else begin
            press_cnt_q <= press_cnt_d;
            lock_vld_q  <= lock_vld_d;
            lock_key_q  <= lock_key_d;
        end
    end

    assign press_cnt = press_cnt_q;
`endif

endmodule : ps2_kbd_rx

// File: tb/tb_ps2_kbd_rx.sv
// -----------------------------------------------------------------------------
// tb_ps2_kbd_rx
// Directed self-checking bench for ps2_kbd_rx. PS/2 frames are bit-banged on
// ps2_clk/ps2_data; expected events are written out by hand.
// -----------------------------------------------------------------------------
module tb_ps2_kbd_rx;

    localparam int FIFO_DEPTH  = 8;
    localparam int SYNC_STAGES = 3;
    localparam int TIMEOUT_CYC = 100;
    localparam int CNT_W       = 2;
    localparam int HALF        = 8;   // clk cycles per PS/2 half period

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_break;
    logic       ev_ext;
    logic [3:0] fifo_count;
    logic       frame_err;
    logic       overflow;
    logic       clr_err;
`ifdef PS2_PRESS_CNT_EN
    logic [CNT_W-1:0] press_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ps2_kbd_rx #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_break   (ev_break),
        .ev_ext     (ev_ext),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .clr_err    (clr_err)
`ifdef PS2_PRESS_CNT_EN
        ,
        .press_cnt  (press_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Head of FIFO must be a valid event with these fields.
    task automatic chk_head(input string tag, input logic [7:0] code,
                            input logic brk, input logic ext);
        chk(tag, {ev_valid, ev_break, ev_ext, ev_code}, {1'b1, brk, ext, code});
    endtask

    task automatic fall(input logic d);
        ps2_data = d;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
    endtask

    task automatic rise();
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_raw(input logic [10:0] bits);
        for (int i = 0; i < 11; i++) begin
            fall(bits[i]);
            rise();
        end
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par);
        send_raw({1'b1, (~^b) ^ flip_par, b, 1'b0});
    endtask

    task automatic pop();
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] fr;
        rst      = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        ev_ready = 1'b0;
        clr_err  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {ev_valid, ev_code, ev_break, ev_ext, fifo_count, frame_err, overflow}, '0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // --- 0x1C, latency: valid one cycle after the stop-bit sample pulse
        fr = {1'b1, 1'b0, 8'h1C, 1'b0};
        for (int i = 0; i < 10; i++) begin
            fall(fr[i]);
            rise();
        end
        fall(fr[10]);
        repeat (SYNC_STAGES) @(posedge clk);
        @(negedge clk);
        chk("lat_pulse_cycle", ev_valid, 1'b0);
        @(negedge clk);
        chk("lat_next_cycle", ev_valid, 1'b1);
        rise();
        chk_head("make_1c", 8'h1C, 1'b0, 1'b0);
        chk("count_1", fifo_count, 4'd1);
        pop();
        chk("empty_after_pop", {ev_valid, fifo_count}, 5'd0);

        // --- prefix folding
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        chk("ext_brk_count", fifo_count, 4'd1);
        chk_head("ext_brk_75", 8'h75, 1'b1, 1'b1);
        pop();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h6B, 1'b0);
        chk_head("ext_6b", 8'h6B, 1'b0, 1'b1);
        pop();
        send_frame(8'hE1, 1'b0);
        chk_head("e1_plain", 8'hE1, 1'b0, 1'b0);
        pop();

        // --- parity error after E0: byte lost, prefix dropped
        send_frame(8'hE0, 1'b0);
        send_frame(8'h1C, 1'b1);
        chk("parity_no_event", fifo_count, 4'd0);
        chk("parity_err", frame_err, 1'b1);
        send_frame(8'h32, 1'b0);
        chk_head("after_err_32", 8'h32, 1'b0, 1'b0);
        pop();
        pulse_clr();
        chk("clr_frame_err", frame_err, 1'b0);
        send_raw({1'b0, 1'b1, 8'h1C, 1'b0});   // bad stop bit
        chk("stop_err", {frame_err, fifo_count}, {1'b1, 4'd0});
        pulse_clr();

        // --- overflow
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0);
        chk("full_no_ovf", {fifo_count, overflow}, {4'd8, 1'b0});
        send_frame(8'h09, 1'b0);
        chk("ovf_count", fifo_count, 4'd8);
        chk("ovf_flag", overflow, 1'b1);
        chk_head("ovf_head", 8'h01, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            chk_head($sformatf("drain_%0d", i), 8'(i), 1'b0, 1'b0);
            pop();
        end
        chk("drained", {ev_valid, fifo_count}, 5'd0);
        chk("hold_last_code", ev_code, 8'h08);
        pulse_clr();
        chk("clr_overflow", overflow, 1'b0);

        // --- timeout of a partial frame
        fr = {1'b1, 1'b0, 8'h29, 1'b0};
        for (int i = 0; i < 5; i++) begin
            fall(fr[i]);
            rise();
        end
        repeat (TIMEOUT_CYC / 2) @(negedge clk);
        chk("tmo_not_yet", frame_err, 1'b0);
        repeat (TIMEOUT_CYC) @(negedge clk);
        chk("tmo_err", frame_err, 1'b1);
        send_frame(8'h29, 1'b0);
        chk_head("after_tmo_29", 8'h29, 1'b0, 1'b0);
        chk("after_tmo_count", fifo_count, 4'd1);

        // --- asynchronous reset mid-frame
        fr = {1'b1, 1'b0, 8'h1C, 1'b0};
        for (int i = 0; i < 3; i++) fall(fr[i]);
        #2 rst = 1'b0;
        #1;
        chk("async_reset",
            {ev_valid, ev_code, ev_break, ev_ext, fifo_count, frame_err, overflow}, '0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h1C, 1'b0);
        chk_head("post_reset_1c", 8'h1C, 1'b0, 1'b0);
        chk("post_reset_state", {fifo_count, frame_err}, {4'd1, 1'b0});

`ifdef PS2_PRESS_CNT_EN
        // --- press counter with typematic suppression and wrap (CNT_W = 2)
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        ev_ready = 1'b1;
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        chk("press_repeat", press_cnt, 2'd1);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        chk("press_two", press_cnt, 2'd2);
        send_frame(8'h1D, 1'b0);
        chk("press_three", press_cnt, 2'd3);
        send_frame(8'h1E, 1'b0);
        chk("press_wrap", press_cnt, 2'd0);
        ev_ready = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ps2_kbd_rx

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
Parametrised PS/2 keyboard receiver. Successor to the single-byte scancode display receiver.
- Deserialises 11-bit PS/2 frames and checks each one.
- Folds E0/F0 prefixes into make/break events with an extended flag.
- Buffers events in a FIFO with a valid/ready consumer interface.
- Reports framing, parity, timeout and overflow errors.
- Sits between the PS/2 pins and the keyboard consumer (display logic or CPU MMIO).

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of 2, ≥2
- SYNC_STAGES, 3, ps2_clk/ps2_data synchroniser flops; ≥2
- TIMEOUT_CYC, 50000, clk cycles without a ps2_clk falling edge before a partial frame is aborted
- CNT_W, 16, width of press counter (optional feature only)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock pin
- ps2_data  in  1  raw PS/2 data pin
- ev_valid  out  1  FIFO head event valid
- ev_ready  in  1  consumer accepts head event when ev_valid&ev_ready
- ev_code  out  8  scancode of head event
- ev_break  out  1  head event is a key release
- ev_ext  out  1  head event carried an E0 prefix
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently stored
- frame_err  out  1  sticky: start/stop/parity/timeout error seen
- overflow  out  1  sticky: event dropped because FIFO was full
- clr_err  in  1  synchronous clear of frame_err and overflow
- press_cnt  out  CNT_W  distinct key presses (only with PS2_PRESS_CNT_EN)

Behaviour:
- Reset: rst low clears everything asynchronously, regardless of state. All outputs go to 0: ev_valid, ev_code, ev_break, ev_ext, fifo_count, frame_err, overflow, press_cnt. Bit counter, prefix FSM, FIFO pointers and synchronisers are also 0. A frame in progress is lost.
- Sampling: ps2_clk passes through SYNC_STAGES flops. The sample pulse is (prev sync = 1 & current = 0). ps2_data is synchronised with the same depth and sampled on that pulse.
- Bit counter: 0..10. Bits are stored LSB first: bit0 = start, bits 1-8 = data, bit9 = parity, bit10 = stop. The counter returns to 0 after bit10.
- Frame check on bit10 sample:
  - Valid frame: start = 0, stop = 1, and ^{data,parity} = 1 (odd parity). The byte goes to the prefix FSM.
  - Any failure: byte discarded, frame_err set, FSM forced to IDLE.
- Timeout: counter ≠ 0 and no sample pulse for TIMEOUT_CYC consecutive cycles → counter = 0, frame_err set, FSM to IDLE.
- Prefix FSM states: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0 → EXT; F0 → BRK; other byte → emit {code, brk=0, ext=0}.
  - EXT: F0 → EXT_BRK; E0 → stay; other → emit {code, 0, 1}, then IDLE.
  - BRK: F0/E0 → stay (BRK); other → emit {code, 1, 0}, then IDLE.
  - EXT_BRK: other → emit {code, 1, 1}, then IDLE.
  - E1 is not a prefix: it is emitted as an ordinary code.
- Latency: emit occurs on the cycle of the stop-bit sample pulse. The FIFO is written at the end of that cycle, so ev_valid/fields are visible the next cycle (first-word fall-through).
- FIFO:
  - Pop when ev_valid & ev_ready.
  - Push when emit & (not full or pop same cycle).
  - Full with push and pop in the same cycle: both happen, count unchanged.
  - Full with push, no pop: event dropped, overflow set, count unchanged.
  - Empty: ev_valid = 0; ev_code/ev_break/ev_ext hold their last value. ev_ready is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- clr_err and an error event in the same cycle: the error wins, so the flag stays 1.

Optional Feature:
- Macro: PS2_PRESS_CNT_EN.
- Defined: press_cnt port exists.
  - Increments by 1 on each make event (break = 0) actually written to the FIFO, unless {ext, code} equals the last counted make with no break of that key since. This suppresses typematic repeat.
  - A break of that key clears the repeat lock.
  - Wraps from 2^CNT_W-1 to 0.
- Undefined: port and logic absent. All other behaviour identical.

Decomposition:
- Package ps2_pkg:
  - localparams PS2_PFX_EXT = 8'hE0, PS2_PFX_BRK = 8'hF0, PS2_FRAME_BITS = 11.
  - typedef ps2_event_t {logic brk; logic ext; logic [7:0] code;}.
  - enum ps2_pfx_state_t {IDLE, EXT, BRK, EXT_BRK}.
- Sub-module ps2_event_fifo: synchronous first-word-fall-through FIFO of ps2_event_t, parametrised by FIFO_DEPTH, with count output. The top block holds the synchroniser, deserialiser, timeout and prefix FSM.

Test Plan:
- Send frame 0x1C (start 0, data LSB first, parity 0, stop 1) → one event code = 0x1C, brk = 0, ext = 0; ev_valid rises 1 cycle after the stop-bit sample; fifo_count = 1.
- Send E0,F0,75 with ev_ready = 0 → exactly one event {0x75, brk = 1, ext = 1}; no events for the prefix bytes.
- Send 0x1C with parity bit 1 → no event, frame_err = 1. Then a good 0x32 → event 0x32, no prefix carried over. clr_err → frame_err = 0.
- Hold ev_ready = 0 and send FIFO_DEPTH+1 = 9 make codes → fifo_count = 8, overflow = 1, head = first code. Pop all → codes 1-8 in order, ninth lost.
- Stop ps2_clk after 5 bits for TIMEOUT_CYC cycles → frame_err = 1, counter reset. Next full frame 0x29 → event 0x29. Assert rst low mid-frame → all outputs 0 immediately.
- With PS2_PRESS_CNT_EN: send 1C,1C,1C,F0,1C,1C → press_cnt = 2. Under a small CNT_W, wraparound from max value to 0.
